// File: rtl/pmem_arbiter_if.sv
// rtl/pmem_arbiter_if.sv - icache/dcache/memory line-port bundle for pmem_arbiter
interface pmem_arbiter_if #(
  parameter int LINE_WIDTH = 256,
  parameter int ADDR_WIDTH = 32
);
  logic                  icache_pmem_read;
  logic [ADDR_WIDTH-1:0] icache_pmem_address;
  logic [LINE_WIDTH-1:0] icache_pmem_rdata;
  logic                  icache_pmem_resp;

  logic                  dcache_pmem_read;
  logic                  dcache_pmem_write;
  logic [ADDR_WIDTH-1:0] dcache_pmem_address;
  logic [LINE_WIDTH-1:0] dcache_pmem_wdata;
  logic [LINE_WIDTH-1:0] dcache_pmem_rdata;
  logic                  dcache_pmem_resp;

  logic                  pmem_read;
  logic                  pmem_write;
  logic [ADDR_WIDTH-1:0] pmem_address;
  logic [LINE_WIDTH-1:0] pmem_wdata;
  logic [LINE_WIDTH-1:0] pmem_rdata;
  logic                  pmem_resp;

  // master: the caches and memory around the arbiter; slave: the arbiter itself
  modport master (
    output icache_pmem_read, icache_pmem_address,
    input  icache_pmem_rdata, icache_pmem_resp,
    output dcache_pmem_read, dcache_pmem_write, dcache_pmem_address, dcache_pmem_wdata,
    input  dcache_pmem_rdata, dcache_pmem_resp,
    input  pmem_read, pmem_write, pmem_address, pmem_wdata,
    output pmem_rdata, pmem_resp
  );

  modport slave (
    input  icache_pmem_read, icache_pmem_address,
    output icache_pmem_rdata, icache_pmem_resp,
    input  dcache_pmem_read, dcache_pmem_write, dcache_pmem_address, dcache_pmem_wdata,
    output dcache_pmem_rdata, dcache_pmem_resp,
    output pmem_read, pmem_write, pmem_address, pmem_wdata,
    input  pmem_rdata, pmem_resp
  );
endinterface

// File: rtl/pmem_arbiter.sv
// rtl/pmem_arbiter.sv - one-at-a-time icache/dcache arbiter onto a shared cacheline memory port
module pmem_arbiter #(
  parameter int LINE_WIDTH = 256,
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 16,
  parameter int RR_ENABLE  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  pmem_arbiter_if.slave        bus,
  output logic [CNT_WIDTH-1:0] icache_grant_count,
  output logic [CNT_WIDTH-1:0] dcache_grant_count
);
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] I_BUSY  = 2'd1;
  localparam logic [1:0] D_BUSY  = 2'd2;
  localparam logic [1:0] RELEASE = 2'd3;

  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

  logic [1:0]            state;
  logic                  last_grant;
  logic                  i_req;
  logic                  d_req;
  logic                  pick_d;
  logic                  pick_i;
  logic [ADDR_WIDTH-1:0] grant_addr;
  logic [LINE_WIDTH-1:0] grant_wdata;

  // On a tie, round-robin hands the line to whoever did not win last time
  always_comb begin
    i_req       = bus.icache_pmem_read;
    d_req       = bus.dcache_pmem_read | bus.dcache_pmem_write;
    pick_d      = d_req && (!i_req || (RR_ENABLE == 0) || (last_grant == GRANT_I));
    pick_i      = i_req && !pick_d;
    grant_addr  = pick_d ? bus.dcache_pmem_address : bus.icache_pmem_address;
    grant_wdata = (pick_d && bus.dcache_pmem_write) ? bus.dcache_pmem_wdata : bus.pmem_wdata;
  end

  assign bus.icache_pmem_rdata = bus.pmem_rdata;
  assign bus.dcache_pmem_rdata = bus.pmem_rdata;
  assign bus.icache_pmem_resp  = (state == I_BUSY) && bus.pmem_resp;
  assign bus.dcache_pmem_resp  = (state == D_BUSY) && bus.pmem_resp;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state              <= IDLE;
      last_grant         <= GRANT_I;
      bus.pmem_read      <= 1'b0;
      bus.pmem_write     <= 1'b0;
      bus.pmem_address   <= '0;
      bus.pmem_wdata     <= '0;
      icache_grant_count <= '0;
      dcache_grant_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_d || pick_i) begin
            bus.pmem_address <= grant_addr;
            bus.pmem_wdata   <= grant_wdata;
          end
          if (pick_d) begin
            // A combined read+write is issued as the writeback only
            state          <= D_BUSY;
            last_grant     <= GRANT_D;
            bus.pmem_write <= bus.dcache_pmem_write;
            bus.pmem_read  <= !bus.dcache_pmem_write;
            if (dcache_grant_count != '1) dcache_grant_count <= dcache_grant_count + CNT_ONE;
          end else if (pick_i) begin
            state          <= I_BUSY;
            last_grant     <= GRANT_I;
            bus.pmem_read  <= 1'b1;
            bus.pmem_write <= 1'b0;
            if (icache_grant_count != '1) icache_grant_count <= icache_grant_count + CNT_ONE;
          end
        end
        I_BUSY, D_BUSY: begin
          if (bus.pmem_resp) begin
            state          <= RELEASE;
            bus.pmem_read  <= 1'b0;
            bus.pmem_write <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pmem_arbiter.sv
// tb/tb_pmem_arbiter.sv - self-checking bench for pmem_arbiter (vectors, corner sequences, random vs model)
module tb_pmem_arbiter;
  localparam int LW  = 256;
  localparam int AW  = 32;
  localparam int CW  = 16;
  localparam int CW2 = 3;
  localparam logic [LW-1:0] A5 = {32{8'hA5}};

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pmem_arbiter_if #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW)) bus ();
  pmem_arbiter_if #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW)) bus2 ();
  logic [CW-1:0]  icnt, dcnt;
  logic [CW2-1:0] icnt2, dcnt2;

  pmem_arbiter #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW), .RR_ENABLE(1)) dut (
    .clk(clk), .rst(rst), .bus(bus), .icache_grant_count(icnt), .dcache_grant_count(dcnt));

  pmem_arbiter #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW2), .RR_ENABLE(0)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2), .icache_grant_count(icnt2), .dcache_grant_count(dcnt2));

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  function automatic logic [LW-1:0] rnd256();
    logic [LW-1:0] r;
    for (int j = 0; j < 8; j++) r[32*j +: 32] = $urandom;
    return r;
  endfunction

  task automatic clear_inputs();
    bus.icache_pmem_read = 0;  bus.icache_pmem_address = '0;
    bus.dcache_pmem_read = 0;  bus.dcache_pmem_write = 0;
    bus.dcache_pmem_address = '0; bus.dcache_pmem_wdata = '0;
    bus.pmem_resp = 0;         bus.pmem_rdata = '0;
    bus2.icache_pmem_read = 0; bus2.icache_pmem_address = '0;
    bus2.dcache_pmem_read = 0; bus2.dcache_pmem_write = 0;
    bus2.dcache_pmem_address = '0; bus2.dcache_pmem_wdata = '0;
    bus2.pmem_resp = 0;        bus2.pmem_rdata = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 0;
    clear_inputs();
    @(negedge clk);
    rst = 1;
  endtask

  typedef struct {
    logic          rst;
    logic          ir;
    logic [AW-1:0] ia;
    logic          dr, dw;
    logic [AW-1:0] da;
    logic [LW-1:0] dwd;
    logic          pr;
    logic [LW-1:0] prd;
    logic          er, ew;
    logic [AW-1:0] ea;
    logic [LW-1:0] ewd;
    logic          eir, edr;
    int            eic, edc;
  } vec_t;
  vec_t vt[$];

  task automatic add(input logic r, ir, input logic [AW-1:0] ia, input logic dr, dw,
                     input logic [AW-1:0] da, input logic [LW-1:0] dwd, input logic pr,
                     input logic [LW-1:0] prd, input logic er, ew, input logic [AW-1:0] ea,
                     input logic [LW-1:0] ewd, input logic eir, edr, input int eic, edc);
    vec_t v;
    v.rst = r; v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw; v.da = da; v.dwd = dwd;
    v.pr = pr; v.prd = prd; v.er = er; v.ew = ew; v.ea = ea; v.ewd = ewd;
    v.eir = eir; v.edr = edr; v.eic = eic; v.edc = edc;
    vt.push_back(v);
  endtask

  // Random-phase reference model: owner 0 none, 1 icache, 2 dcache
  int            m_owner, m_last, m_free, t, delay, win, m_ic, m_dc, n;
  logic          exp_r, exp_w, s_ir, s_dq;
  logic [AW-1:0] exp_a;
  logic [LW-1:0] exp_wd, rd;
  logic          i_pend, i_granted, d_pend, d_granted;
  logic [AW-1:0] i_addr, d_addr;
  logic [LW-1:0] d_wd;
  int            d_type;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    clear_inputs();

    // rst, ir, ia, dr, dw, da, dwd, pr, prd | er, ew, ea, ewd, eir, edr, eic, edc
    add(0, 0, 0,      0, 0, 0,      0,      0, 0,     0, 0, 0,      0,      0, 0, 0, 0);
    add(1, 1, 'h1000, 0, 0, 0,      0,      0, 0,     0, 0, 0,      0,      0, 0, 0, 0);
    add(1, 1, 'h1000, 0, 0, 0,      0,      0, 0,     1, 0, 'h1000, 0,      0, 0, 1, 0);
    add(1, 1, 'h1000, 0, 0, 0,      0,      0, 0,     1, 0, 'h1000, 0,      0, 0, 1, 0);
    add(1, 1, 'h1000, 0, 0, 0,      0,      0, 0,     1, 0, 'h1000, 0,      0, 0, 1, 0);
    add(1, 1, 'h1000, 0, 0, 0,      0,      1, A5,    1, 0, 'h1000, 0,      1, 0, 1, 0);
    add(1, 0, 'h1000, 0, 0, 0,      0,      1, 'h33,  0, 0, 'h1000, 0,      0, 0, 1, 0);
    add(1, 0, 'h1000, 0, 0, 0,      0,      1, 'h44,  0, 0, 'h1000, 0,      0, 0, 1, 0);
    add(1, 0, 'h1000, 0, 0, 0,      0,      0, 0,     0, 0, 'h1000, 0,      0, 0, 1, 0);
    add(0, 1, 'h1000, 0, 0, 0,      0,      1, 0,     0, 0, 0,      0,      0, 0, 0, 0);
    add(1, 1, 'h100,  0, 1, 'h200,  'h1234, 0, 0,     0, 0, 0,      0,      0, 0, 0, 0);
    add(1, 1, 'h100,  0, 1, 'h200,  'h1234, 0, 0,     0, 1, 'h200,  'h1234, 0, 0, 0, 1);
    add(1, 1, 'h100,  0, 1, 'h200,  'h1234, 1, 'h55,  0, 1, 'h200,  'h1234, 0, 1, 0, 1);
    add(1, 1, 'h100,  0, 0, 'h200,  'h1234, 0, 0,     0, 0, 'h200,  'h1234, 0, 0, 0, 1);
    add(1, 1, 'h100,  0, 0, 'h200,  'h1234, 0, 0,     0, 0, 'h200,  'h1234, 0, 0, 0, 1);
    add(1, 1, 'h100,  0, 0, 'h200,  'h1234, 0, 0,     1, 0, 'h100,  'h1234, 0, 0, 1, 1);
    add(1, 1, 'h100,  0, 0, 'h200,  'h1234, 1, 'h77,  1, 0, 'h100,  'h1234, 1, 0, 1, 1);
    add(1, 0, 'h100,  0, 0, 'h200,  'h1234, 0, 0,     0, 0, 'h100,  'h1234, 0, 0, 1, 1);
    add(1, 0, 'h100,  1, 1, 'h300,  'hBEEF, 0, 0,     0, 0, 'h100,  'h1234, 0, 0, 1, 1);
    add(1, 0, 'h100,  1, 0, 'hDEAD, 'hFFFF, 0, 0,     0, 1, 'h300,  'hBEEF, 0, 0, 1, 2);
    add(1, 0, 'h100,  1, 0, 'hDEAD, 'hFFFF, 0, 0,     0, 1, 'h300,  'hBEEF, 0, 0, 1, 2);
    add(1, 0, 'h100,  1, 0, 'hDEAD, 'hFFFF, 1, 'h99,  0, 1, 'h300,  'hBEEF, 0, 1, 1, 2);
    add(1, 0, 'h100,  0, 0, 'hDEAD, 'hFFFF, 0, 0,     0, 0, 'h300,  'hBEEF, 0, 0, 1, 2);
    add(1, 0, 'h100,  0, 0, 'hDEAD, 'hFFFF, 0, 0,     0, 0, 'h300,  'hBEEF, 0, 0, 1, 2);

    foreach (vt[k]) begin
      @(negedge clk);
      rst = vt[k].rst;
      bus.icache_pmem_read = vt[k].ir;  bus.icache_pmem_address = vt[k].ia;
      bus.dcache_pmem_read = vt[k].dr;  bus.dcache_pmem_write = vt[k].dw;
      bus.dcache_pmem_address = vt[k].da; bus.dcache_pmem_wdata = vt[k].dwd;
      bus.pmem_resp = vt[k].pr;         bus.pmem_rdata = vt[k].prd;
      #1;
      chk($sformatf("vec%0d pmem_read", k), bus.pmem_read, vt[k].er);
      chk($sformatf("vec%0d pmem_write", k), bus.pmem_write, vt[k].ew);
      chk($sformatf("vec%0d pmem_address", k), bus.pmem_address, vt[k].ea);
      chk($sformatf("vec%0d pmem_wdata", k), bus.pmem_wdata, vt[k].ewd);
      chk($sformatf("vec%0d icache_resp", k), bus.icache_pmem_resp, vt[k].eir);
      chk($sformatf("vec%0d dcache_resp", k), bus.dcache_pmem_resp, vt[k].edr);
      chk($sformatf("vec%0d icache_rdata", k), bus.icache_pmem_rdata, vt[k].prd);
      chk($sformatf("vec%0d dcache_rdata", k), bus.dcache_pmem_rdata, vt[k].prd);
      chk($sformatf("vec%0d icache_count", k), icnt, vt[k].eic);
      chk($sformatf("vec%0d dcache_count", k), dcnt, vt[k].edc);
    end

    // Reset in the middle of an icache transaction, then a normal grant afterwards
    do_reset();
    bus.icache_pmem_read = 1; bus.icache_pmem_address = 'h40;
    @(negedge clk); #1;
    chk("rstseq granted", bus.pmem_read, 1);
    @(negedge clk);
    rst = 0; bus.pmem_resp = 1; bus.pmem_rdata = A5;
    #1;
    chk("rstseq pmem_read", bus.pmem_read, 0);
    chk("rstseq pmem_write", bus.pmem_write, 0);
    chk("rstseq pmem_address", bus.pmem_address, 0);
    chk("rstseq icache_resp", bus.icache_pmem_resp, 0);
    chk("rstseq dcache_resp", bus.dcache_pmem_resp, 0);
    chk("rstseq icache_count", icnt, 0);
    @(negedge clk);
    rst = 1; bus.pmem_resp = 0; bus.icache_pmem_address = 'h80;
    @(negedge clk); #1;
    chk("rstseq regrant read", bus.pmem_read, 1);
    chk("rstseq regrant addr", bus.pmem_address, 'h80);
    chk("rstseq regrant count", icnt, 1);
    @(negedge clk);
    bus.pmem_resp = 1; #1;
    chk("rstseq regrant resp", bus.icache_pmem_resp, 1);
    @(negedge clk);
    bus.pmem_resp = 0; bus.icache_pmem_read = 0;

    // Both held high: round-robin alternates starting with dcache
    do_reset();
    bus.icache_pmem_read = 1; bus.icache_pmem_address = 'h10;
    bus.dcache_pmem_read = 1; bus.dcache_pmem_address = 'h20;
    for (int g = 0; g < 6; g++) begin
      n = 0;
      @(negedge clk); #1;
      while (!(bus.pmem_read || bus.pmem_write) && n < 8) begin @(negedge clk); #1; n++; end
      chk($sformatf("rr grant%0d arrived", g), n < 8, 1);
      chk($sformatf("rr grant%0d addr", g), bus.pmem_address, (g % 2 == 0) ? 'h20 : 'h10);
      bus.pmem_resp = 1; #1;
      chk($sformatf("rr grant%0d dcache_resp", g), bus.dcache_pmem_resp, g % 2 == 0);
      chk($sformatf("rr grant%0d icache_resp", g), bus.icache_pmem_resp, g % 2 == 1);
      @(negedge clk);
      bus.pmem_resp = 0;
    end
    chk("rr icache_count", icnt, 3);
    chk("rr dcache_count", dcnt, 3);
    bus.icache_pmem_read = 0; bus.dcache_pmem_read = 0;

    // Fixed priority: dcache wins every tie, narrow counter saturates
    do_reset();
    bus2.icache_pmem_read = 1; bus2.icache_pmem_address = 'h10;
    bus2.dcache_pmem_read = 1; bus2.dcache_pmem_address = 'h20;
    for (int g = 0; g < 9; g++) begin
      n = 0;
      @(negedge clk); #1;
      while (!(bus2.pmem_read || bus2.pmem_write) && n < 8) begin @(negedge clk); #1; n++; end
      chk($sformatf("fp grant%0d arrived", g), n < 8, 1);
      chk($sformatf("fp grant%0d addr", g), bus2.pmem_address, 'h20);
      bus2.pmem_resp = 1; #1;
      chk($sformatf("fp grant%0d dcache_resp", g), bus2.dcache_pmem_resp, 1);
      @(negedge clk);
      bus2.pmem_resp = 0;
      if (g == 5) chk("fp icache_count after 6", icnt2, 0);
    end
    chk("fp dcache_count saturated", dcnt2, 7);
    chk("fp icache_count", icnt2, 0);
    bus2.icache_pmem_read = 0; bus2.dcache_pmem_read = 0;

    // Randomized traffic against a transaction-level model
    do_reset();
    m_owner = 0; m_last = 1; m_free = 0; t = 0; delay = 0; m_ic = 0; m_dc = 0;
    exp_r = 0; exp_w = 0; exp_a = '0; exp_wd = '0;
    i_pend = 0; i_granted = 0; d_pend = 0; d_granted = 0;
    i_addr = '0; d_addr = '0; d_wd = '0; d_type = 0;
    for (int cyc = 0; cyc < 2500; cyc++) begin
      @(negedge clk);
      rd = rnd256();
      if (m_owner != 0) begin
        bus.pmem_resp = (delay == 0);
        if (delay != 0) delay--;
      end else begin
        bus.pmem_resp = ($urandom_range(0, 5) == 0);
      end
      bus.pmem_rdata = rd;

      if (!i_pend && $urandom_range(0, 2) == 0) begin i_pend = 1; i_addr = $urandom; end
      if (i_granted) begin
        if ($urandom_range(0, 3) == 0) begin
          bus.icache_pmem_address = $urandom;
          bus.icache_pmem_read = 1'($urandom_range(0, 1));
        end
      end else begin
        bus.icache_pmem_read = i_pend; bus.icache_pmem_address = i_addr;
      end

      if (!d_pend && $urandom_range(0, 2) == 0) begin
        d_pend = 1; d_addr = $urandom; d_wd = rnd256(); d_type = $urandom_range(0, 2);
      end
      if (d_granted) begin
        if ($urandom_range(0, 3) == 0) begin
          bus.dcache_pmem_address = $urandom; bus.dcache_pmem_wdata = rnd256();
          bus.dcache_pmem_read = 1'($urandom_range(0, 1));
          bus.dcache_pmem_write = 1'($urandom_range(0, 1));
        end
      end else begin
        bus.dcache_pmem_read  = d_pend && (d_type != 1);
        bus.dcache_pmem_write = d_pend && (d_type != 0);
        bus.dcache_pmem_address = d_addr; bus.dcache_pmem_wdata = d_wd;
      end

      #1;
      chk("rnd pmem_read", bus.pmem_read, (m_owner != 0) && exp_r);
      chk("rnd pmem_write", bus.pmem_write, (m_owner != 0) && exp_w);
      chk("rnd pmem_address", bus.pmem_address, exp_a);
      chk("rnd pmem_wdata", bus.pmem_wdata, exp_wd);
      chk("rnd icache_resp", bus.icache_pmem_resp, (m_owner == 1) && bus.pmem_resp);
      chk("rnd dcache_resp", bus.dcache_pmem_resp, (m_owner == 2) && bus.pmem_resp);
      chk("rnd icache_rdata", bus.icache_pmem_rdata, rd);
      chk("rnd dcache_rdata", bus.dcache_pmem_rdata, rd);
      chk("rnd icache_count", icnt, m_ic);
      chk("rnd dcache_count", dcnt, m_dc);

      if (m_owner != 0) begin
        if (bus.pmem_resp) begin
          if (m_owner == 1) begin i_pend = 0; i_granted = 0; end
          else begin d_pend = 0; d_granted = 0; end
          m_owner = 0;
          m_free = t + 2;
        end
      end else if (t >= m_free) begin
        s_ir = bus.icache_pmem_read;
        s_dq = bus.dcache_pmem_read || bus.dcache_pmem_write;
        if (s_ir || s_dq) begin
          win = (s_ir && s_dq) ? ((m_last == 1) ? 2 : 1) : (s_dq ? 2 : 1);
          m_owner = win; m_last = win; delay = $urandom_range(0, 3);
          if (win == 2) begin
            exp_a = bus.dcache_pmem_address;
            exp_w = bus.dcache_pmem_write;
            exp_r = !bus.dcache_pmem_write;
            if (bus.dcache_pmem_write) exp_wd = bus.dcache_pmem_wdata;
            if (m_dc < (1 << CW) - 1) m_dc++;
            d_granted = 1;
          end else begin
            exp_a = bus.icache_pmem_address; exp_r = 1; exp_w = 0;
            if (m_ic < (1 << CW) - 1) m_ic++;
            i_granted = 1;
          end
        end
      end
      t++;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pmem_arbiter.md
Name: pmem_arbiter

Overview:
- Sits between the split L1 caches (icache, dcache) and the single shared cacheline memory port.
- Grants exactly one cache-line transaction at a time and registers the winner's address, wdata and command toward memory.
- Routes the memory response back to the owner.
- Keeps per-requester grant counters for performance debug.

Parameters:
- LINE_WIDTH, 256: cache line data width in bits.
- ADDR_WIDTH, 32: line address width.
- CNT_WIDTH, 16: width of the saturating grant counters.
- RR_ENABLE, 1: 1 = round-robin on tie; 0 = fixed priority to dcache.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- icache_pmem_read  in  1  icache line fill request.
- icache_pmem_address  in  ADDR_WIDTH  icache line address.
- icache_pmem_rdata  out  LINE_WIDTH  fill data to icache.
- icache_pmem_resp  out  1  icache transaction complete.
- dcache_pmem_read  in  1  dcache line fill request.
- dcache_pmem_write  in  1  dcache writeback request.
- dcache_pmem_address  in  ADDR_WIDTH  dcache line address.
- dcache_pmem_wdata  in  LINE_WIDTH  writeback data.
- dcache_pmem_rdata  out  LINE_WIDTH  fill data to dcache.
- dcache_pmem_resp  out  1  dcache transaction complete.
- pmem_read  out  1  memory read command.
- pmem_write  out  1  memory write command.
- pmem_address  out  ADDR_WIDTH  memory address.
- pmem_wdata  out  LINE_WIDTH  memory write data.
- pmem_rdata  in  LINE_WIDTH  memory read data.
- pmem_resp  in  1  memory transaction complete.
- icache_grant_count  out  CNT_WIDTH  icache grants since reset.
- dcache_grant_count  out  CNT_WIDTH  dcache grants since reset.

Behaviour:
- Reset (rst low, any time, asynchronous):
  - state = IDLE.
  - pmem_read, pmem_write, pmem_address, pmem_wdata, both grant counters = 0.
  - last_grant = ICACHE.
  - An in-flight transaction is abandoned; no resp is produced for it.
- States: IDLE, I_BUSY, D_BUSY, RELEASE.
- IDLE:
  - Samples requests each cycle. A dcache request is dcache_pmem_read or dcache_pmem_write.
  - Only icache requesting -> I_BUSY.
  - Only dcache requesting -> D_BUSY.
  - Both requesting: RR_ENABLE=1 grants the requester not equal to last_grant; RR_ENABLE=0 grants dcache.
  - No request -> stay in IDLE.
- Grant (IDLE -> BUSY edge):
  - Register the winner's address, and wdata if it is a dcache write.
  - Set pmem_read or pmem_write; it is visible the cycle after the request is sampled.
  - Update last_grant and increment the winner's counter. Counters saturate at all-ones.
- dcache read and write both high:
  - Write takes precedence: pmem_write=1, pmem_read=0.
  - The read is not retried by the arbiter.
- BUSY:
  - pmem command, address and wdata are held stable regardless of requester input changes.
  - Wait for pmem_resp; there is no timeout.
- pmem_resp in BUSY:
  - Same cycle, combinationally: owner's *_pmem_resp = 1 and owner's *_pmem_rdata = pmem_rdata.
  - Next state = RELEASE.
  - Non-owner resp stays 0.
- rdata outputs: pmem_rdata is passed through to both rdata outputs at all times; only resp qualifies it.
- RELEASE:
  - pmem_read = pmem_write = 0.
  - No sampling, so the requester has one cycle to drop its request.
  - Unconditional transition to IDLE.
- Minimum spacing: the earliest next grant is sampled 2 cycles after resp; back-to-back commands are separated by at least 2 idle cycles on pmem.
- Spurious pmem_resp in IDLE or RELEASE is ignored; no resp is forwarded.
- A requester that drops its request while BUSY is still serviced to completion.
- Latency, idle arbiter, memory responding D cycles after command:
  - request sampled at cycle 0; command asserted at cycle 1; resp at cycle 1+D.

Test Plan:
- Single icache read, addr 0x0000_1000, memory responds after 3 cycles with 0xA5..A5 -> pmem_read=1 with pmem_address=0x1000 from cycle 1; icache_pmem_resp=1 for exactly one cycle with rdata 0xA5..A5; dcache_pmem_resp stays 0; icache_grant_count=1.
- Simultaneous icache read 0x100 and dcache write 0x200 (data 0x1234), RR_ENABLE=1, straight after reset -> dcache granted first (pmem_write=1, addr 0x200, wdata 0x1234). After resp and RELEASE, icache granted at 0x100; counts 1/1.
- Both requesters held high continuously for 6 grants -> grants alternate D,I,D,I,D,I; with RR_ENABLE=0 all 6 go to dcache and icache_grant_count stays 0.
- During D_BUSY, change dcache_pmem_address to 0xDEAD and drop the write -> pmem_address and pmem_wdata unchanged; transaction completes and dcache_pmem_resp pulses once.
- Assert rst low mid-I_BUSY, then assert pmem_resp -> all outputs immediately 0; no icache_pmem_resp; counters 0; after release, a new request is granted normally.
- Inject pmem_resp while IDLE and during RELEASE -> no resp forwarded to either cache; state stays unaffected; dcache read+write together -> only pmem_write asserted.
